// File: rtl/stack_prog_sequencer_pkg.sv
// Shared encodings for the stack/memory transfer engine program sequencer:
// instruction opcodes, engine command codes and sequencer FSM states.
package stack_prog_sequencer_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHC = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_JMP   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    typedef enum logic [1:0] {
        CMD_PUSHC = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_STORE = 2'b10
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        HALT   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Handshake watchdog: counts enabled cycles and flags the cycle whose count
// reaches LIMIT. Clear has priority; the count saturates at LIMIT.
module seq_timeout_ctr #(
    parameter int LIMIT = 15,
    localparam int CW = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] count;

    // Combinational so the owner can abort on the same edge the count hits LIMIT.
    assign expired = en && !clr && (count == CW'(LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != CW'(LIMIT)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/stack_prog_sequencer.sv
// Program sequencer: fetches and decodes instruction ROM words, issues
// PUSHC/LOAD/STORE to the engine over valid/done, and handles JMP/HALT locally.
module stack_prog_sequencer
    import stack_prog_sequencer_pkg::*;
#(
    parameter int PC_LEN   = 8,
    parameter int DATA_LEN = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic [PC_LEN-1:0]     imem_addr,
    output logic                  imem_rd_en,
    input  logic [DATA_LEN+3:0]   imem_data,
    output logic                  cmd_valid,
    output logic [1:0]            cmd_op,
    output logic [DATA_LEN-1:0]   cmd_operand,
    input  logic                  cmd_done,
    output logic                  busy,
    output logic                  halted,
    output logic                  err,
    output logic [PC_LEN-1:0]     pc
);

    localparam int JW = (PC_LEN < DATA_LEN) ? PC_LEN : DATA_LEN;

    seq_state_t          state, state_nxt;
    logic [PC_LEN-1:0]   pc_q, pc_nxt;
    logic                err_q, err_nxt;
    cmd_op_t             op_q, op_nxt;
    logic [DATA_LEN-1:0] operand_q, operand_nxt;

    logic [3:0]          opcode;
    logic [DATA_LEN-1:0] operand;
    logic [PC_LEN-1:0]   jmp_target;
    logic                tmo_clr, tmo_en, tmo_expired;

    assign opcode     = imem_data[DATA_LEN+3:DATA_LEN];
    assign operand    = imem_data[DATA_LEN-1:0];
    assign jmp_target = PC_LEN'(operand[JW-1:0]);

    // Done in the same cycle as the limit counts as completion, not timeout.
    assign tmo_en  = (state == ISSUE) && !cmd_done;
    assign tmo_clr = (state != ISSUE) || cmd_done;

    seq_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pc_q      <= '0;
            err_q     <= 1'b0;
            op_q      <= CMD_PUSHC;
            operand_q <= '0;
        end else begin
            state     <= state_nxt;
            pc_q      <= pc_nxt;
            err_q     <= err_nxt;
            op_q      <= op_nxt;
            operand_q <= operand_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        err_nxt     = err_q;
        op_nxt      = op_q;
        operand_nxt = operand_q;
        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    err_nxt   = 1'b0;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_NOP: begin
                        pc_nxt    = pc_q + PC_LEN'(1);
                        state_nxt = FETCH;
                    end
                    OP_JMP: begin
                        pc_nxt    = jmp_target;
                        state_nxt = FETCH;
                    end
                    OP_HALT: state_nxt = HALT;
                    OP_PUSHC: begin
                        op_nxt      = CMD_PUSHC;
                        operand_nxt = operand;
                        state_nxt   = ISSUE;
                    end
                    OP_LOAD: begin
                        op_nxt      = CMD_LOAD;
                        operand_nxt = operand;
                        state_nxt   = ISSUE;
                    end
                    OP_STORE: begin
                        op_nxt      = CMD_STORE;
                        operand_nxt = operand;
                        state_nxt   = ISSUE;
                    end
                    default: begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                endcase
            end
            ISSUE: begin
                if (cmd_done) begin
                    pc_nxt    = pc_q + PC_LEN'(1);
                    state_nxt = FETCH;
                end else if (tmo_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = HALT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset clears them asynchronously.
    assign imem_rd_en  = (state == FETCH);
    assign imem_addr   = imem_rd_en ? pc_q : '0;
    assign cmd_valid   = (state == ISSUE);
    assign cmd_op      = op_q;
    assign cmd_operand = operand_q;
    assign busy        = (state != IDLE) && (state != HALT);
    assign halted      = (state == HALT);
    assign err         = err_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_stack_prog_sequencer.sv
// Scoreboard bench for stack_prog_sequencer: directed programs in a model ROM,
// a scripted engine, and a monitor that checks fetches and commands from queues.
module tb_stack_prog_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [11:0] imem_data = '0;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_operand;
    logic        cmd_done = 1'b0;
    logic        busy, halted, err;
    logic [7:0]  pc;

    typedef struct {
        logic [1:0] op;
        logic [7:0] operand;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_fetch[$];
    logic [11:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;
    int done_lat = 3;      // engine asserts done on this ISSUE cycle; 0 = never
    int valid_run = 0, low_run = 0, last_valid_len = 0, last_gap = 0;
    logic eng_prev_v = 1'b0;
    logic mon_prev_v = 1'b0;
    cmd_t cur_cmd;

    stack_prog_sequencer #(.PC_LEN(8), .DATA_LEN(8), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_data   (imem_data),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_done    (cmd_done),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= rom[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] arg);
        return {op, arg};
    endfunction

    // Scripted engine; also records valid-high run length and low gap between commands.
    always @(negedge clk) begin
        if (cmd_valid) begin
            valid_run++;
            cmd_done = (done_lat != 0) && (valid_run == done_lat);
            if (!eng_prev_v) last_gap = low_run;
            low_run = 0;
        end else begin
            if (eng_prev_v) last_valid_len = valid_run;
            valid_run = 0;
            cmd_done = 1'b0;
            low_run++;
        end
        eng_prev_v = cmd_valid;
    end

    // Monitor: pops expected fetch addresses and commands whenever the DUT presents them.
    always @(negedge clk) begin
        if (imem_rd_en) begin
            check("fetch_expected", 32'(exp_fetch.size() > 0), 32'd1);
            if (exp_fetch.size() > 0) check("fetch_addr", 32'(imem_addr), 32'(exp_fetch.pop_front()));
        end
        if (cmd_valid && !mon_prev_v) begin
            check("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
            if (exp_cmd.size() > 0) begin
                cur_cmd = exp_cmd.pop_front();
                check("cmd_op", 32'(cmd_op), 32'(cur_cmd.op));
                check("cmd_operand", 32'(cmd_operand), 32'(cur_cmd.operand));
            end
        end else if (cmd_valid && mon_prev_v) begin
            check("cmd_stable", 32'({cmd_op, cmd_operand}), 32'({cur_cmd.op, cur_cmd.operand}));
        end
        mon_prev_v = cmd_valid;
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    task automatic start_prog();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halted(output int cyc);
        cyc = 0;
        while (!halted && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic check_drained(input string name);
        check({name, "_fetch_drained"}, 32'(exp_fetch.size()), 32'd0);
        check({name, "_cmd_drained"}, 32'(exp_cmd.size()), 32'd0);
    endtask

    int cyc;

    initial begin
        clear_rom();
        #3;
        check("reset_outputs", 32'({imem_addr, imem_rd_en, cmd_valid, cmd_op, cmd_operand, busy, halted, err, pc}), 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_busy", 32'({busy, halted}), 32'd0);

        // PUSHC 0x2A, HALT with done on the third ISSUE cycle.
        rom[0] = ins(4'h1, 8'h2A);
        rom[1] = ins(4'h5, 8'h00);
        done_lat = 3;
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        exp_cmd.push_back('{2'b00, 8'h2A});
        start_prog();
        check("t1_busy", 32'(busy), 32'd1);
        wait_halted(cyc);
        check("t1_cycles", 32'(cyc), 32'd7);
        check("t1_state", 32'({halted, busy, err}), 32'b100);
        check("t1_pc", 32'(pc), 32'd1);
        check("t1_valid_len", 32'(last_valid_len), 32'd3);
        check_drained("t1");

        // LOAD 0x10, STORE 0x20, HALT with done on the second ISSUE cycle.
        clear_rom();
        rom[0] = ins(4'h2, 8'h10);
        rom[1] = ins(4'h3, 8'h20);
        rom[2] = ins(4'h5, 8'h00);
        done_lat = 2;
        for (int i = 0; i < 3; i++) exp_fetch.push_back(8'(i));
        exp_cmd.push_back('{2'b01, 8'h10});
        exp_cmd.push_back('{2'b10, 8'h20});
        start_prog();
        wait_halted(cyc);
        check("t2_cycles", 32'(cyc), 32'd10);
        check("t2_pc", 32'(pc), 32'd2);
        check("t2_gap", 32'(last_gap), 32'd2);
        check("t2_state", 32'({halted, err}), 32'b10);
        check_drained("t2");

        // JMP 5; 5: NOP; 6: HALT.
        clear_rom();
        rom[0] = ins(4'h4, 8'h05);
        rom[5] = ins(4'h0, 8'h00);
        rom[6] = ins(4'h5, 8'h00);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h05); exp_fetch.push_back(8'h06);
        start_prog();
        wait_halted(cyc);
        check("t3_cycles", 32'(cyc), 32'd6);
        check("t3_pc", 32'(pc), 32'd6);
        check("t3_state", 32'({halted, err}), 32'b10);
        check_drained("t3");

        // PUSHC 0x01 never completed: timeout after 15 ISSUE cycles; start mid-run ignored.
        clear_rom();
        rom[0] = ins(4'h1, 8'h01);
        done_lat = 0;
        exp_fetch.push_back(8'h00);
        exp_cmd.push_back('{2'b00, 8'h01});
        start_prog();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_halted(cyc);
        check("t4_cycles", 32'(cyc + 6), 32'd17);
        check("t4_valid_len", 32'(last_valid_len), 32'd15);
        check("t4_state", 32'({halted, busy, err, cmd_valid}), 32'b1010);
        check("t4_pc", 32'(pc), 32'd0);
        check_drained("t4");
        rom[0] = ins(4'h5, 8'h00);
        done_lat = 3;
        exp_fetch.push_back(8'h00);
        start_prog();
        check("t4_err_cleared", 32'(err), 32'd0);
        wait_halted(cyc);
        check("t4_restart_cycles", 32'(cyc), 32'd2);
        check("t4_restart_state", 32'({halted, err}), 32'b10);
        check_drained("t4r");

        // Illegal opcode 0xF at address 3.
        clear_rom();
        for (int i = 0; i < 3; i++) rom[i] = ins(4'h0, 8'h00);
        rom[3] = ins(4'hF, 8'h77);
        for (int i = 0; i < 4; i++) exp_fetch.push_back(8'(i));
        start_prog();
        wait_halted(cyc);
        check("t5_cycles", 32'(cyc), 32'd8);
        check("t5_state", 32'({halted, err, cmd_valid}), 32'b110);
        check("t5_pc", 32'(pc), 32'd3);
        check_drained("t5");

        // NOP at 0xFF wraps pc to 0; address 0 becomes HALT after its first read.
        clear_rom();
        rom[0]    = ins(4'h4, 8'hFF);
        rom[8'hFF] = ins(4'h0, 8'h00);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'hFF); exp_fetch.push_back(8'h00);
        start_prog();
        @(negedge clk);
        rom[0] = ins(4'h5, 8'h00);
        wait_halted(cyc);
        check("t6_cycles", 32'(cyc + 1), 32'd6);
        check("t6_pc_wrap", 32'(pc), 32'd0);
        check("t6_state", 32'({halted, err}), 32'b10);
        check_drained("t6");

        // Reset asserted while a command is outstanding.
        clear_rom();
        rom[0] = ins(4'h1, 8'h33);
        done_lat = 0;
        exp_fetch.push_back(8'h00);
        exp_cmd.push_back('{2'b00, 8'h33});
        start_prog();
        cyc = 0;
        while (!cmd_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("t7_cmd_seen", 32'(cmd_valid), 32'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t7_async_reset", 32'({imem_addr, imem_rd_en, cmd_valid, cmd_op, cmd_operand, busy, halted, err, pc}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("t7_idle_after_reset", 32'({busy, halted, cmd_valid}), 32'd0);
        check_drained("t7");
        rom[0] = ins(4'h5, 8'h00);
        exp_fetch.push_back(8'h00);
        start_prog();
        wait_halted(cyc);
        check("t7_resume", 32'({halted, err, pc}), 32'h200);
        check_drained("t7r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_prog_sequencer.md
Name: stack_prog_sequencer

Overview:
Program sequencer for the stack/memory transfer engine. It fetches instruction words from a synchronous instruction ROM and decodes them. Each transfer instruction is issued to the engine as a command with a valid/done handshake; jump, halt and illegal instructions are handled locally. It sits between the instruction ROM and the engine's control and address-constant inputs, so a program can be run without a host driving every transfer.

Parameters:
PC_LEN, 8, program-counter and instruction-address width
DATA_LEN, 8, operand width (constant or data-memory address)
TIMEOUT, 15, maximum cycles to wait for cmd_done before the error abort (≥1)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; starts execution at PC 0 from IDLE or HALT
imem_addr  out  PC_LEN  instruction ROM address
imem_rd_en  out  1  instruction ROM read strobe
imem_data  in  4+DATA_LEN  instruction word, valid the cycle after imem_rd_en
cmd_valid  out  1  command request to the engine
cmd_op  out  2  00 push constant, 01 load (mem→stack), 10 store (stack→mem)
cmd_operand  out  DATA_LEN  constant or memory address for the command
cmd_done  in  1  one-cycle completion pulse from the engine
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
err  out  1  sticky; set on an illegal opcode or a timeout
pc  out  PC_LEN  current program counter

Behaviour:
- Instruction format: opcode = imem_data[DATA_LEN+3:DATA_LEN], operand = imem_data[DATA_LEN-1:0].
- Opcodes: 0 NOP; 1 PUSHC k; 2 LOAD a; 3 STORE a; 4 JMP t (pc←t[PC_LEN-1:0], zero-extended if PC_LEN>DATA_LEN); 5 HALT; 6–15 illegal.
- Reset (asynchronous): state=IDLE, pc=0, timeout counter=0. All outputs are 0. No outputs are tri-stated.
- IDLE: waits for start. On start: pc←0, err←0, next state FETCH.
- FETCH (1 cycle): imem_rd_en=1, imem_addr=pc. Next state DECODE.
- DECODE (1 cycle): the instruction word is registered.
  - NOP: pc←pc+1, next FETCH.
  - JMP: pc←t, next FETCH.
  - HALT: next HALT, pc unchanged.
  - PUSHC/LOAD/STORE: cmd_op/cmd_operand registered, next ISSUE.
  - Illegal: err←1, next HALT.
- ISSUE: cmd_valid=1. cmd_op and cmd_operand stay stable until done.
  - cmd_done is sampled only in ISSUE. On cmd_done: cmd_valid drops the next cycle, pc←pc+1, next FETCH, counter cleared.
  - The counter increments each ISSUE cycle without done. When it reaches TIMEOUT: err←1, cmd_valid←0, next HALT.
  - cmd_done outside ISSUE is ignored.
- HALT: halted=1, busy=0. start re-enters as from IDLE (pc←0, err cleared).
- start while busy is ignored.
- Cost per instruction: NOP/JMP take 2 cycles. A command takes 2 + n cycles, where n ≥1 is the cycle count up to and including cmd_done.
- pc increment wraps modulo 2^PC_LEN (max→0) with no flag.
- pc output = internal pc. imem_addr = pc while imem_rd_en=1, otherwise 0.
- Reset asserted mid-command: cmd_valid drops immediately and asynchronously. The engine must tolerate an abandoned command.

Decomposition:
- Shared package: opcode constants (NOP..HALT), cmd_op encodings (CMD_PUSHC=2'b00, CMD_LOAD=2'b01, CMD_STORE=2'b10), FSM state encodings (IDLE, FETCH, DECODE, ISSUE, HALT).
- One natural sub-module: seq_timeout_ctr (load/clear, enable, terminal flag at TIMEOUT), reusable by other handshake controllers.

Test Plan:
- Program [PUSHC 0x2A, HALT]; engine returns done 3 cycles after cmd_valid rises → one command op=00 operand=0x2A; halted=1 at pc=1; err=0; total 7 cycles from start to halted.
- Program [LOAD 0x10, STORE 0x20, HALT] → commands op=01/0x10 then op=10/0x20 in order; cmd_valid low for ≥2 cycles between commands; pc ends at 2.
- Program at 0: JMP 0x05; location 5: NOP, HALT → fetch addresses 0, 5, 6; no cmd_valid; halted at pc=6.
- Engine never asserts done on PUSHC 0x01, TIMEOUT=15 → cmd_valid high exactly 15 cycles; then err=1, halted=1; next start clears err and refetches address 0.
- Opcode 0xF at address 3 → err=1, halted=1, pc=3, no command issued. Separately: NOP at 0xFF → pc wraps to 0x00.
- rstn pulled low while cmd_valid=1 → all outputs 0 in the same cycle; after release, state IDLE and start required to resume.
